fp_add_arbiter: RTL



---
 rtl/fp_add_arbiter.sv | 117 +++++++++++
 1 files changed

// File: rtl/fp_add_arbiter.sv
// Round-robin front end sharing one fixed-latency pipelined float32 adder among
// NUM_REQ requesters, with a tag pipeline routing each result to a response slot.
module fp_add_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int LATENCY = 7,
   parameter int TAG_W   = 3
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ-1:0][31:0] req_a,
   input  logic [NUM_REQ-1:0][31:0] req_b,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic [NUM_REQ-1:0]       resp_valid,
   output logic [NUM_REQ-1:0][31:0] resp_z,
   input  logic [NUM_REQ-1:0]       resp_ready,
   output logic [31:0]              adder_a,
   output logic [31:0]              adder_b,
   input  logic [31:0]              adder_z,
   output logic                     idle
);

   logic [NUM_REQ-1:0]           w_busy;
   logic [NUM_REQ-1:0]           w_elig;
   logic [NUM_REQ-1:0]           w_hi;
   logic [NUM_REQ-1:0]           w_grant;
   logic [NUM_REQ-1:0]           w_wb;
   logic [TAG_W-1:0]             w_win;
   logic                         w_hs;
   logic [31:0]                  w_op_a;
   logic [31:0]                  w_op_b;

   logic [TAG_W-1:0]             r_ptr;
   logic [31:0]                  r_adder_a;
   logic [31:0]                  r_adder_b;
   logic [LATENCY:0]             r_vld_pipe;
   logic [LATENCY:0][TAG_W-1:0]  r_tag_pipe;
   logic [NUM_REQ-1:0]           r_inflight;
   logic [NUM_REQ-1:0]           r_resp_valid;
   logic [NUM_REQ-1:0][31:0]     r_resp_z;

   assign w_busy = r_inflight | r_resp_valid;
   assign w_elig = req_valid & ~w_busy;

   // Lowest eligible index above the pointer wins; otherwise wrap to the lowest overall.
   always_comb begin
      w_hi    = '0;
      w_grant = '0;
      w_win   = '0;
      w_hs    = |w_elig;
      w_op_a  = '0;
      w_op_b  = '0;
      for (int j = 0; j < NUM_REQ; j++)
         w_hi[j] = w_elig[j] && (j > int'(r_ptr));
      for (int j = NUM_REQ-1; j >= 0; j--)
         if (w_elig[j]) w_win = TAG_W'(j);
      for (int j = NUM_REQ-1; j >= 0; j--)
         if (w_hi[j]) w_win = TAG_W'(j);
      for (int j = 0; j < NUM_REQ; j++) begin
         w_grant[j] = w_hs && (TAG_W'(j) == w_win);
         w_op_a     = w_op_a | (req_a[j] & {32{w_grant[j]}});
         w_op_b     = w_op_b | (req_b[j] & {32{w_grant[j]}});
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ptr      <= TAG_W'(NUM_REQ-1);
         r_adder_a  <= '0;
         r_adder_b  <= '0;
         r_vld_pipe <= '0;
         r_tag_pipe <= '0;
      end else begin
         if (w_hs) begin
            r_ptr     <= w_win;
            r_adder_a <= w_op_a;
            r_adder_b <= w_op_b;
         end
         // Stage LATENCY lines up with adder_z for the operands launched from stage 0.
         r_vld_pipe <= {r_vld_pipe[LATENCY-1:0], w_hs};
         r_tag_pipe <= {r_tag_pipe[LATENCY-1:0], w_win};
      end
   end

   genvar g;
   generate
      for (g = 0; g < NUM_REQ; g++) begin : g_slot
         assign w_wb[g] = r_vld_pipe[LATENCY] && (r_tag_pipe[LATENCY] == TAG_W'(g));

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               r_inflight[g]   <= 1'b0;
               r_resp_valid[g] <= 1'b0;
               r_resp_z[g]     <= '0;
            end else begin
               if (w_wb[g])         r_inflight[g] <= 1'b0;
               else if (w_grant[g]) r_inflight[g] <= 1'b1;
               // Busy blocks re-issue, so a writeback never meets a drain on the same slot.
               if (w_wb[g]) begin
                  r_resp_valid[g] <= 1'b1;
                  r_resp_z[g]     <= adder_z;
               end else if (resp_ready[g]) begin
                  r_resp_valid[g] <= 1'b0;
               end
            end
         end
      end
   endgenerate

   assign req_ready  = w_grant;
   assign resp_valid = r_resp_valid;
   assign resp_z     = r_resp_z;
   assign adder_a    = r_adder_a;
   assign adder_b    = r_adder_b;
   assign idle       = ~|w_busy;

endmodule
